pll_phase_seq: RTL and testbench
================================

Name: pll_phase_seq

Overview:
- Sequencer for the ECP5 EHXPLLL dynamic phase-shift port (PHASESEL, PHASEDIR, PHASESTEP).
- A client requests N phase steps on one PLL output. The block generates correctly timed PHASESTEP pulses.
- It tracks the accumulated phase offset per output and gates all activity on a debounced PLL lock.
- Sits beside the clock-generation PLL, clocked from a stable reference-domain clock (typically the 25 MHz input).

Parameters:
- SETUP, 4: cycles PHASESEL/PHASEDIR are held stable before the first step pulse (>=1).
- PULSE, 4: cycles PHASESTEP is held low per step (>=1).
- GAP, 8: cycles PHASESTEP is held high between pulses and after the last one (>=1).
- LOCK_WAIT, 1024: consecutive synchronised-locked cycles before lock is declared good (>=2).
- CNT_W, 8: width of step count and offset registers.

Ports:
- clk  in  1  block clock, stable, not derived from the PLL being controlled
- rst  in  1  synchronous reset, active high
- pll_locked  in  1  PLL LOCK, asynchronous to clk
- lock_ok  out  1  lock debounced and good
- req  in  1  request strobe, sampled while rdy=1
- rdy  out  1  block can accept a request
- sel  in  2  target output: 0=CLKOP, 1=CLKOS, 2=CLKOS2, 3=CLKOS3
- dir  in  1  0=advance (offset+1 per step), 1=retard (offset-1 per step)
- steps  in  CNT_W  number of steps, unsigned
- busy  out  1  sequence in progress
- done  out  1  one-cycle pulse on normal completion
- aborted  out  1  one-cycle pulse when a sequence is killed by lock loss
- ofs  out  CNT_W  signed accumulated offset of channel sel, combinational mux of the offset registers
- pll_phasesel  out  2  to EHXPLLL PHASESEL[1:0]
- pll_phasedir  out  1  to EHXPLLL PHASEDIR
- pll_phasestep  out  1  to EHXPLLL PHASESTEP, idle high

Behaviour:
- Reset (rst=1, synchronous): state WAIT_LOCK; lock counter 0; lock_ok=0; rdy=0; busy=0; done=0; aborted=0; pll_phasesel=0; pll_phasedir=0; pll_phasestep=1; all four offsets 0.
- Lock sync: 2-flop synchroniser on pll_locked gives lk.
  - lk=1: counter increments, saturating at LOCK_WAIT.
  - lk=0: counter clears.
  - lock_ok=1 exactly while counter==LOCK_WAIT.
- rdy = (state==IDLE) & lock_ok & ~rst.
- busy = 1 in SETUP, PULSE and GAP.
- States:
  - WAIT_LOCK -> IDLE when lock_ok=1.
  - IDLE, req&rdy: latch sel, dir, steps into working registers.
    - steps==0: done pulses the next cycle, stay IDLE; rdy deasserts for that one cycle.
    - Otherwise go to SETUP; pll_phasesel/pll_phasedir take the latched values in the same cycle.
  - SETUP: hold for SETUP cycles -> PULSE.
  - PULSE: pll_phasestep=0 for PULSE cycles. On the last PULSE cycle: remaining-=1 and offset[sel]+=1 (dir=0) or -=1 (dir=1), modulo 2^CNT_W (wraps, no saturation). -> GAP.
  - GAP: pll_phasestep=1 for GAP cycles; then remaining>0 -> PULSE (no new SETUP), else -> IDLE with done=1 for one cycle.
- pll_phasesel and pll_phasedir hold their last values while IDLE. They change only on request acceptance.
- Total cycles from accept to done for N>0: SETUP + N*(PULSE+GAP) + 1 (done registered on exit).
- Lock loss: lk=0 in any state (clears lock_ok) forces the next state to WAIT_LOCK.
  - pll_phasestep=1 that cycle; working registers cleared.
  - aborted pulses one cycle if the state was SETUP/PULSE/GAP; done is not asserted.
  - All offsets clear to 0, because the PLL relocks at static phase.
  - A step pulse cut short does not update the offset.
- req while rdy=0 is ignored, not queued.
- rst has priority over lock loss; neither done nor aborted is pulsed on rst.

Test Plan:
- Lock bring-up: rst then pll_locked=1 at cycle 10 -> lock_ok and rdy rise LOCK_WAIT+2 cycles later (+/-1 for sync); pll_phasestep=1 throughout.
- Single sequence: sel=2, dir=0, steps=3 -> pll_phasesel=2 and dir=0 at accept; exactly 3 low pulses each 4 cycles wide, 8 high between; done 4+3*12+1=41 cycles after accept; ofs (sel=2)=3.
- Retard and wrap: sel=1, dir=1, steps=1 from offset 0 -> ofs=0xFF; a subsequent steps=2, dir=0 -> ofs=0x01.
- Zero steps: steps=0 -> no pulse on pll_phasestep; done pulses the next cycle; offsets unchanged.
- Abort: drop pll_locked during the 2nd pulse of a 5-step run -> pll_phasestep high within 3 cycles; aborted one pulse; no done; all ofs=0; rdy low until LOCK_WAIT cycles after relock.
- Ignored request: req asserted while busy -> no effect; only the original sequence's pulse count is observed.

Source files
------------

// File: rtl/pll_phase_seq.sv
`default_nettype none
// ============================================================================
//  Module : pll_phase_seq
//  Brief  : Drives the ECP5 EHXPLLL dynamic phase-shift port. It issues timed
//           PHASESTEP pulses and tracks the phase offset of each output.
//  Rev    : 1.0  initial release
// ============================================================================
module pll_phase_seq #(
    parameter int SETUP     = 4,
    parameter int PULSE     = 4,
    parameter int GAP       = 8,
    parameter int LOCK_WAIT = 1024,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pll_locked,
    output logic             lock_ok,
    input  logic             req,
    output logic             rdy,
    input  logic [1:0]       sel,
    input  logic             dir,
    input  logic [CNT_W-1:0] steps,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic [CNT_W-1:0] ofs,
    output logic [1:0]       pll_phasesel,
    output logic             pll_phasedir,
    output logic             pll_phasestep
);

    localparam int c_LCK_W   = $clog2(LOCK_WAIT + 1);
    localparam int c_TMAX_SP = (SETUP > PULSE) ? SETUP : PULSE;
    localparam int c_TMAX    = (c_TMAX_SP > GAP) ? c_TMAX_SP : GAP;
    localparam int c_TMR_W   = $clog2(c_TMAX + 1);

    localparam logic [c_LCK_W-1:0] c_LOCK_MAX  = c_LCK_W'(LOCK_WAIT);
    localparam logic [c_TMR_W-1:0] c_SETUP_END = c_TMR_W'(SETUP - 1);
    localparam logic [c_TMR_W-1:0] c_PULSE_END = c_TMR_W'(PULSE - 1);
    localparam logic [c_TMR_W-1:0] c_GAP_END   = c_TMR_W'(GAP - 1);

    localparam logic [2:0] c_ST_WAIT_LOCK = 3'd0;
    localparam logic [2:0] c_ST_IDLE      = 3'd1;
    localparam logic [2:0] c_ST_SETUP     = 3'd2;
    localparam logic [2:0] c_ST_PULSE     = 3'd3;
    localparam logic [2:0] c_ST_GAP       = 3'd4;

    logic [2:0]         r_state;
    logic [2:0]         w_nxt;
    logic               r_lk_meta;
    logic               r_lk;
    logic [c_LCK_W-1:0] r_lock_cnt;
    logic [c_TMR_W-1:0] r_tmr;
    logic [1:0]         r_sel;
    logic               r_dir;
    logic [CNT_W-1:0]   r_rem;
    logic [CNT_W-1:0]   r_ofs [4];
    logic [1:0]         r_phasesel;
    logic               r_phasedir;
    logic               r_done;
    logic               r_aborted;
    logic               r_zdone;
    logic               w_accept;
    logic               w_pulse_last;
    logic               w_gap_last;

    // pll_locked is asynchronous to clk: two-flop synchroniser, then debounce
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lk_meta  <= 1'b0;
            r_lk       <= 1'b0;
            r_lock_cnt <= '0;
        end else begin
            r_lk_meta <= pll_locked;
            r_lk      <= r_lk_meta;
            if (!r_lk)
                r_lock_cnt <= '0;
            else if (r_lock_cnt != c_LOCK_MAX)
                r_lock_cnt <= r_lock_cnt + c_LCK_W'(1);
        end
    end

    assign lock_ok      = (r_lock_cnt == c_LOCK_MAX);
    assign w_accept     = req & rdy & r_lk;
    assign w_pulse_last = (r_state == c_ST_PULSE) && (r_tmr == c_PULSE_END);
    assign w_gap_last   = (r_state == c_ST_GAP) && (r_tmr == c_GAP_END);

    always_ff @(posedge clk) begin
        if (rst) r_state <= c_ST_WAIT_LOCK;
        else     r_state <= w_nxt;
    end

    always_comb begin
        w_nxt = r_state;
        if (!r_lk) begin
            w_nxt = c_ST_WAIT_LOCK;
        end else begin
            case (r_state)
                c_ST_WAIT_LOCK: if (lock_ok) w_nxt = c_ST_IDLE;
                c_ST_IDLE:      if (w_accept && (steps != '0)) w_nxt = c_ST_SETUP;
                c_ST_SETUP:     if (r_tmr == c_SETUP_END) w_nxt = c_ST_PULSE;
                c_ST_PULSE:     if (w_pulse_last) w_nxt = c_ST_GAP;
                c_ST_GAP:       if (w_gap_last) w_nxt = (r_rem != '0) ? c_ST_PULSE : c_ST_IDLE;
                default:        w_nxt = c_ST_WAIT_LOCK;
            endcase
        end
    end

    // PHASESTEP is combinational so a lock loss releases it in the same cycle
    always_comb begin
        busy          = (r_state == c_ST_SETUP) || (r_state == c_ST_PULSE) ||
                        (r_state == c_ST_GAP);
        pll_phasestep = !((r_state == c_ST_PULSE) && r_lk);
        rdy           = (r_state == c_ST_IDLE) && lock_ok && !rst && !r_zdone;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tmr      <= '0;
            r_sel      <= '0;
            r_dir      <= 1'b0;
            r_rem      <= '0;
            r_phasesel <= '0;
            r_phasedir <= 1'b0;
            r_done     <= 1'b0;
            r_aborted  <= 1'b0;
            r_zdone    <= 1'b0;
            for (int i = 0; i < 4; i++) r_ofs[i] <= '0;
        end else begin
            r_done    <= 1'b0;
            r_aborted <= 1'b0;
            r_zdone   <= 1'b0;
            r_tmr     <= (w_nxt != r_state || !busy) ? '0 : r_tmr + c_TMR_W'(1);
            if (!r_lk) begin
                // PLL relocks at static phase, so every offset returns to zero
                r_aborted <= busy;
                r_sel     <= '0;
                r_dir     <= 1'b0;
                r_rem     <= '0;
                for (int i = 0; i < 4; i++) r_ofs[i] <= '0;
            end else begin
                if (w_accept) begin
                    r_sel <= sel;
                    r_dir <= dir;
                    r_rem <= steps;
                    if (steps == '0) begin
                        r_done  <= 1'b1;
                        r_zdone <= 1'b1;
                    end else begin
                        r_phasesel <= sel;
                        r_phasedir <= dir;
                    end
                end
                if (w_pulse_last) begin
                    r_rem        <= r_rem - CNT_W'(1);
                    r_ofs[r_sel] <= r_dir ? r_ofs[r_sel] - CNT_W'(1)
                                          : r_ofs[r_sel] + CNT_W'(1);
                end
                if (w_gap_last && (r_rem == '0))
                    r_done <= 1'b1;
            end
        end
    end

    assign done         = r_done;
    assign aborted      = r_aborted;
    assign ofs          = r_ofs[sel];
    assign pll_phasesel = r_phasesel;
    assign pll_phasedir = r_phasedir;

endmodule
`default_nettype wire

// File: tb/tb_pll_phase_seq.sv
`default_nettype none
// ============================================================================
//  Module : tb_pll_phase_seq
//  Brief  : Randomised self-checking bench for pll_phase_seq.
//  Rev    : 1.0  initial release
// ============================================================================
module tb_pll_phase_seq;

    localparam int SETUP     = 4;
    localparam int PULSE     = 4;
    localparam int GAP       = 8;
    localparam int LOCK_WAIT = 1024;
    localparam int CNT_W     = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             pll_locked;
    logic             lock_ok;
    logic             req;
    logic             rdy;
    logic [1:0]       sel;
    logic             dir;
    logic [CNT_W-1:0] steps;
    logic             busy;
    logic             done;
    logic             aborted;
    logic [CNT_W-1:0] ofs;
    logic [1:0]       pll_phasesel;
    logic             pll_phasedir;
    logic             pll_phasestep;

    int               n_vec = 0;
    int               n_err = 0;
    logic [CNT_W-1:0] m_ofs [4];

    pll_phase_seq #(
        .SETUP(SETUP), .PULSE(PULSE), .GAP(GAP),
        .LOCK_WAIT(LOCK_WAIT), .CNT_W(CNT_W)
    ) u_dut (
        .clk(clk), .rst(rst), .pll_locked(pll_locked), .lock_ok(lock_ok),
        .req(req), .rdy(rdy), .sel(sel), .dir(dir), .steps(steps),
        .busy(busy), .done(done), .aborted(aborted), .ofs(ofs),
        .pll_phasesel(pll_phasesel), .pll_phasedir(pll_phasedir),
        .pll_phasestep(pll_phasestep)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_ofs(input string tag);
        for (int i = 0; i < 4; i++) begin
            sel = 2'(i);
            #1;
            chk($sformatf("%s_ofs%0d", tag, i), ofs, m_ofs[i]);
        end
    endtask

    task automatic wait_rdy(input int bound);
        int k;
        k = 0;
        while (rdy !== 1'b1 && k < bound) begin
            tick();
            k++;
        end
        if (rdy !== 1'b1) chk("rdy_timeout", rdy, 1);
    endtask

    // One request; expectations come from timing arithmetic and a per-channel offset table
    task automatic run_seq(input logic [1:0] s, input logic d, input logic [7:0] n, input bit inject);
        int pulses, low_run, high_run, first_low, done_at, exp_done, n_abort;
        wait_rdy(64);
        sel = s; dir = d; steps = n; req = 1'b1;
        tick();
        req = 1'b0;
        exp_done = (n == 0) ? 1 : SETUP + int'(n) * (PULSE + GAP) + 1;
        pulses = 0; low_run = 0; high_run = 0; first_low = 0; done_at = 0; n_abort = 0;
        for (int t = 1; t <= exp_done + 20; t++) begin
            if (inject && t == 6) begin req = 1'b1; sel = ~s; dir = ~d; steps = 8'd2; end
            if (inject && t == 9) begin req = 1'b0; sel = s; dir = d; end
            if (pll_phasestep === 1'b0) begin
                if (low_run == 0) begin
                    pulses++;
                    if (pulses == 1) first_low = t;
                    else chk("gap_w", high_run, GAP);
                end
                low_run++;
            end else begin
                if (low_run != 0) begin
                    chk("pulse_w", low_run, PULSE);
                    low_run = 0;
                    high_run = 0;
                end
                high_run++;
            end
            if (aborted === 1'b1) n_abort++;
            if (done === 1'b1) begin
                done_at = t;
                break;
            end
            tick();
        end
        chk("done_lat", done_at, exp_done);
        chk("pulses", pulses, n);
        chk("rdy_at_done", rdy, (n != 0));
        chk("busy_at_done", busy, 0);
        chk("no_abort", n_abort, 0);
        if (n != 0) begin
            chk("first_low", first_low, SETUP + 1);
            chk("tail_gap", high_run, GAP + 1);
            chk("phasesel", pll_phasesel, s);
            chk("phasedir", pll_phasedir, d);
        end
        tick();
        chk("done_1cyc", done, 0);
        m_ofs[s] = d ? m_ofs[s] - n : m_ofs[s] + n;
        check_ofs("seq");
        sel = s;
    endtask

    task automatic relock_check(input string tag);
        int c_ok, c_rdy;
        c_ok = -1; c_rdy = -1;
        pll_locked = 1'b1;
        for (int t = 1; t <= LOCK_WAIT + 20; t++) begin
            tick();
            if (pll_phasestep !== 1'b1) chk({tag, "_ps_idle"}, pll_phasestep, 1);
            if (c_ok < 0 && lock_ok === 1'b1) c_ok = t;
            if (c_rdy < 0 && rdy === 1'b1) begin
                c_rdy = t;
                break;
            end
        end
        chk({tag, "_lockok_lat"}, (c_ok >= LOCK_WAIT + 1) && (c_ok <= LOCK_WAIT + 3), 1);
        chk({tag, "_rdy_lat"}, (c_rdy >= LOCK_WAIT + 2) && (c_rdy <= LOCK_WAIT + 4), 1);
    endtask

    task automatic abort_run();
        int pulses, low_run, k, n_ab, n_dn;
        bit dropped;
        wait_rdy(64);
        sel = 2'($urandom_range(0, 3)); dir = 1'($urandom_range(0, 1)); steps = 8'd5; req = 1'b1;
        tick();
        req = 1'b0;
        pulses = 0; low_run = 0; dropped = 0;
        for (int t = 1; t <= 200; t++) begin
            if (pll_phasestep === 1'b0) begin
                if (low_run == 0) pulses++;
                low_run++;
            end else begin
                low_run = 0;
            end
            if (pulses == 2 && low_run == 2) begin
                pll_locked = 1'b0;
                dropped = 1;
                break;
            end
            tick();
        end
        chk("abort_reached", dropped, 1);
        k = 0;
        while (pll_phasestep !== 1'b1 && k < 5) begin
            tick();
            k++;
        end
        chk("abort_ps_hi", (k <= 3), 1);
        n_ab = 0; n_dn = 0;
        for (int t = 0; t < 10; t++) begin
            if (aborted === 1'b1) n_ab++;
            if (done === 1'b1) n_dn++;
            tick();
        end
        chk("abort_pulse", n_ab, 1);
        chk("abort_nodone", n_dn, 0);
        chk("abort_busy", busy, 0);
        chk("abort_rdy", rdy, 0);
        chk("abort_lockok", lock_ok, 0);
        for (int i = 0; i < 4; i++) m_ofs[i] = '0;
        check_ofs("abort");
        relock_check("relock");
    endtask

    initial begin
        for (int i = 0; i < 4; i++) m_ofs[i] = '0;
        rst = 1'b1; pll_locked = 1'b0; req = 1'b0; sel = 2'd0; dir = 1'b0; steps = '0;
        repeat (3) tick();
        chk("rst_lock_ok", lock_ok, 0);
        chk("rst_rdy", rdy, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_aborted", aborted, 0);
        chk("rst_step", pll_phasestep, 1);
        chk("rst_sel", pll_phasesel, 0);
        chk("rst_dir", pll_phasedir, 0);
        check_ofs("rst");
        rst = 1'b0;
        repeat (10) tick();
        relock_check("bringup");

        run_seq(2'd2, 1'b0, 8'd3, 1'b0);
        run_seq(2'd1, 1'b1, 8'd1, 1'b0);
        run_seq(2'd1, 1'b0, 8'd2, 1'b0);
        run_seq(2'd0, 1'b0, 8'd0, 1'b0);
        run_seq(2'd3, 1'b0, 8'd2, 1'b1);
        run_seq(2'd0, 1'b1, 8'd200, 1'b0);
        abort_run();
        for (int i = 0; i < 20; i++)
            run_seq(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                    8'($urandom_range(0, 6)), ($urandom_range(0, 3) == 0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
